// File: rtl/altusoc_syscon_arb.sv
// Two-master round-robin Wishbone arbiter in front of the syscon register slave.
// Define ALTUSOC_SYSCON_ARB_TIMEOUT_EN to add the slave-ack timeout and the ERR state.
module altusoc_syscon_arb #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [5:0]  i_m0_adr,
   input  logic [31:0] i_m0_dat,
   input  logic [3:0]  i_m0_sel,
   input  logic        i_m0_we,
   input  logic        i_m0_cyc,
   input  logic        i_m0_stb,
   output logic [31:0] o_m0_rdt,
   output logic        o_m0_ack,
   output logic        o_m0_err,
   input  logic [5:0]  i_m1_adr,
   input  logic [31:0] i_m1_dat,
   input  logic [3:0]  i_m1_sel,
   input  logic        i_m1_we,
   input  logic        i_m1_cyc,
   input  logic        i_m1_stb,
   output logic [31:0] o_m1_rdt,
   output logic        o_m1_ack,
   output logic        o_m1_err,
   output logic [5:0]  o_s_adr,
   output logic [31:0] o_s_dat,
   output logic [3:0]  o_s_sel,
   output logic        o_s_we,
   output logic        o_s_cyc,
   output logic        o_s_stb,
   input  logic [31:0] i_s_rdt,
   input  logic        i_s_ack,
   output logic [1:0]  o_gnt
);

`ifdef ALTUSOC_SYSCON_ARB_TIMEOUT_EN
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_BUSY} state_t;
`endif

   state_t      state_q, state_d;
   logic [1:0]  gnt_q, gnt_d;
   logic        last_q, last_d;   // index of the master granted most recently
   logic        sel;
   logic        busy;
   logic        gnt_cyc;
   logic        timeout;

   assign sel     = gnt_q[1];
   assign busy    = (state_q == S_BUSY);
   assign gnt_cyc = sel ? i_m1_cyc : i_m0_cyc;

`ifdef ALTUSOC_SYSCON_ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign timeout = busy && !i_s_ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Counter is held at zero outside BUSY so every grant starts a fresh window
   always_comb begin
      cnt_d = cnt_q;
      if (!busy || i_s_ack) cnt_d = '0;
      else                  cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   // Next-state and grant selection
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            if (i_m0_cyc || i_m1_cyc) begin
               state_d = S_BUSY;
               if (i_m0_cyc && i_m1_cyc) gnt_d = last_q ? 2'b01 : 2'b10;
               else                      gnt_d = i_m0_cyc ? 2'b01 : 2'b10;
            end
         end
         S_BUSY: begin
            if (!gnt_cyc) begin
               state_d = S_IDLE;
               last_d  = sel;
               gnt_d   = 2'b00;
            end else if (timeout) begin
               state_d = S_IDLE;
`ifdef ALTUSOC_SYSCON_ARB_TIMEOUT_EN
               state_d = S_ERR;
`endif
            end
         end
`ifdef ALTUSOC_SYSCON_ARB_TIMEOUT_EN
         S_ERR: begin
            if (!gnt_cyc) begin
               state_d = S_IDLE;
               last_d  = sel;
               gnt_d   = 2'b00;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
            gnt_d   = 2'b00;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         gnt_q   <= 2'b00;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
      end
   end

   // Slave side follows the granted master only while BUSY
   assign o_s_adr = sel ? i_m1_adr : i_m0_adr;
   assign o_s_dat = sel ? i_m1_dat : i_m0_dat;
   assign o_s_sel = sel ? i_m1_sel : i_m0_sel;
   assign o_s_we  = busy && (sel ? i_m1_we : i_m0_we);
   assign o_s_cyc = busy && gnt_cyc;
   assign o_s_stb = busy && (sel ? i_m1_stb : i_m0_stb);

   assign o_m0_rdt = i_s_rdt;
   assign o_m1_rdt = i_s_rdt;
   assign o_m0_ack = busy && gnt_q[0] && i_s_ack;
   assign o_m1_ack = busy && gnt_q[1] && i_s_ack;
   assign o_m0_err = timeout && gnt_q[0];
   assign o_m1_err = timeout && gnt_q[1];
   assign o_gnt    = gnt_q;

endmodule

// File: tb/tb_altusoc_syscon_arb.sv
// Directed bench for altusoc_syscon_arb with a 1-cycle-ack syscon slave model.
// Follows ALTUSOC_SYSCON_ARB_TIMEOUT_EN to pick the expected timeout behaviour.
module tb_altusoc_syscon_arb;

`ifdef ALTUSOC_SYSCON_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam logic [31:0] VERSION = 32'hA150_0001;
   localparam int NV = 22;

   logic        clk, rst_n;
   logic [5:0]  m0_adr, m1_adr, s_adr;
   logic [31:0] m0_dat, m1_dat, s_dat, m0_rdt, m1_rdt, s_rdt;
   logic [3:0]  m0_sel, m1_sel, s_sel;
   logic        m0_we, m0_cyc, m0_stb, m0_ack, m0_err;
   logic        m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
   logic        s_we, s_cyc, s_stb, s_ack;
   logic [1:0]  gnt;
   int          ack_mode;   // 0 normal, 1 forced low, 2 forced high
   int          n_vec, n_err;

   typedef struct packed {
      logic       m0;
      logic       m1;
      logic [1:0] gnt;
      logic       scyc;
      logic       a0;
      logic       a1;
   } vec_t;

   vec_t tbl [NV];

   altusoc_syscon_arb #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_m0_adr(m0_adr), .i_m0_dat(m0_dat), .i_m0_sel(m0_sel), .i_m0_we(m0_we),
      .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .o_m0_rdt(m0_rdt), .o_m0_ack(m0_ack),
      .o_m0_err(m0_err),
      .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .i_m1_sel(m1_sel), .i_m1_we(m1_we),
      .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .o_m1_rdt(m1_rdt), .o_m1_ack(m1_ack),
      .o_m1_err(m1_err),
      .o_s_adr(s_adr), .o_s_dat(s_dat), .o_s_sel(s_sel), .o_s_we(s_we),
      .o_s_cyc(s_cyc), .o_s_stb(s_stb), .i_s_rdt(s_rdt), .i_s_ack(s_ack),
      .o_gnt(gnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Syscon slave: registered single-cycle ack, address 0 returns the version word
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ack <= 1'b0;
         s_rdt <= '0;
      end else begin
         if (ack_mode == 1)      s_ack <= 1'b0;
         else if (ack_mode == 2) s_ack <= 1'b1;
         else                    s_ack <= s_cyc && s_stb && !s_ack;
         s_rdt <= (s_adr == 6'd0) ? VERSION : {26'd0, s_adr};
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic c0, input logic c1);
      @(negedge clk);
      m0_cyc = c0; m0_stb = c0;
      m1_cyc = c1; m1_stb = c1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
      ack_mode = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      m0_adr = 6'd0;  m0_dat = 32'h0; m0_sel = 4'hF;
      m1_adr = 6'd5;  m1_dat = 32'h0; m1_sel = 4'hF;
      // {m0 cyc, m1 cyc, exp gnt, exp s_cyc, exp m0 ack, exp m1 ack}
      tbl = '{
         '{1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0},
         '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0},
         '{1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1},
         '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0},
         '{1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0},
         '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0},
         '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0},
         '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0},
         '{1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1},
         '{1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1},
         '{1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1},
         '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0},
         '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0},
         '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0}
      };

      do_reset();
      #1;
      chk("reset_gnt", 32'(gnt), 32'h0);
      chk("reset_scyc", 32'(s_cyc), 32'h0);
      chk("reset_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'h0);

      // Arbitration, latency, hold and alternation table
      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].m0, tbl[i].m1);
         tick();
         chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
         chk($sformatf("v%0d_scyc", i), 32'(s_cyc), 32'(tbl[i].scyc));
         chk($sformatf("v%0d_acks", i), 32'({m0_ack, m1_ack}), 32'({tbl[i].a0, tbl[i].a1}));
         chk($sformatf("v%0d_err", i), 32'({m0_err, m1_err}), 32'h0);
         if (tbl[i].a0) chk($sformatf("v%0d_rdt0", i), m0_rdt, VERSION);
         if (tbl[i].a1) chk($sformatf("v%0d_rdt1", i), m1_rdt, 32'h0000_0005);
      end

      // Write passthrough, then ack still routed in the cycle the master drops cyc
      @(negedge clk);
      m0_adr = 6'h12; m0_dat = 32'hDEAD_BEEF; m0_sel = 4'h3; m0_we = 1'b1;
      m0_cyc = 1'b1; m0_stb = 1'b1;
      tick();
      chk("wr_gnt", 32'(gnt), 32'h1);
      chk("wr_adr", 32'(s_adr), 32'h12);
      chk("wr_dat", s_dat, 32'hDEAD_BEEF);
      chk("wr_sel_we", 32'({s_sel, s_we}), 32'h7);
      tick();
      chk("wr_ack", 32'(m0_ack), 32'h1);
      @(negedge clk);
      m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
      #1;
      chk("drop_ack_routed", 32'(m0_ack), 32'h1);
      chk("drop_scyc", 32'(s_cyc), 32'h0);
      tick();
      chk("drop_idle_gnt", 32'(gnt), 32'h0);
      m0_adr = 6'd0;

      // Async reset in the middle of a BUSY cycle with ack high
      drive(1'b1, 1'b0);
      tick();
      tick();
      chk("pre_rst_ack", 32'(m0_ack), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_scyc", 32'(s_cyc), 32'h0);
      chk("async_rst_gnt", 32'(gnt), 32'h0);
      chk("async_rst_ack", 32'(m0_ack), 32'h0);
      do_reset();

      // Silent slave: timeout pulse and ERR, or indefinite wait without the feature
      ack_mode = 1;
      drive(1'b1, 1'b1);
      for (int e = 0; e < 4; e++) begin
         tick();
         chk($sformatf("to_e%0d_err0", e), 32'(m0_err), (TO_EN && e == 3) ? 32'h1 : 32'h0);
         chk($sformatf("to_e%0d_err1", e), 32'(m1_err), 32'h0);
         chk($sformatf("to_e%0d_gnt", e), 32'(gnt), 32'h1);
      end
      tick();
      chk("to_after_err0", 32'(m0_err), 32'h0);
      chk("to_after_scyc", 32'(s_cyc), TO_EN ? 32'h0 : 32'h1);
      chk("to_after_gnt", 32'(gnt), 32'h1);
      @(negedge clk);
      ack_mode = 2;
      tick();
      chk("late_ack0", 32'(m0_ack), TO_EN ? 32'h0 : 32'h1);
      chk("late_ack1", 32'(m1_ack), 32'h0);
      drive(1'b0, 1'b1);
      tick();
      chk("to_drop_gnt", 32'(gnt), 32'h0);
      tick();
      chk("to_next_m1_gnt", 32'(gnt), 32'h2);
      @(negedge clk);
      ack_mode = 0;
      drive(1'b0, 1'b0);
      repeat (3) tick();
      chk("end_idle_gnt", 32'(gnt), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
